// File: rtl/sig_meter_core.sv
// Gated signal meter for a word-packed 1-bit sample stream: per gate window it
// counts selected edges and ones and reports the last completed high/low runs.
module sig_meter_core #(
  parameter int unsigned W        = 32,
  parameter int unsigned GATE_CYC = 31250000,
  parameter int unsigned CW       = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          smp_valid,
  input  logic [W-1:0]  smp_data,
  input  logic          run,
  input  logic [1:0]    edge_mode,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [CW-1:0] res_freq,
  output logic [CW-1:0] res_ones,
  output logic [CW-1:0] res_thigh,
  output logic [CW-1:0] res_tlow,
  output logic [2:0]    res_flags
);

  localparam int unsigned NW = $clog2(W + 1);
  localparam int unsigned SW = CW + NW + 2;
  localparam int unsigned GW = (GATE_CYC > 1) ? $clog2(GATE_CYC) : 1;
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYC - 1);

  logic [GW-1:0] gcnt;
  logic          run_d;
  logic          prev;
  logic [CW-1:0] run_acc;
  logic [CW-1:0] thigh;
  logic [CW-1:0] tlow;
  logic [CW-1:0] acc_freq;
  logic [CW-1:0] acc_ones;
  logic          acc_sat;
  logic          acc_seen;

  // Per-word scan, oldest sample first, continuing the run from the last word.
  logic          w_lvl;
  logic          w_rsat;
  logic [CW-1:0] w_racc;
  logic [CW-1:0] w_thigh;
  logic [CW-1:0] w_tlow;
  logic [NW-1:0] w_rise;
  logic [NW-1:0] w_fall;
  logic [NW-1:0] w_ones;

  always_comb begin
    w_lvl   = prev;
    w_racc  = run_acc;
    w_thigh = thigh;
    w_tlow  = tlow;
    w_rise  = '0;
    w_fall  = '0;
    w_ones  = '0;
    w_rsat  = 1'b0;
    for (int unsigned i = 0; i < W; i++) begin
      if (smp_data[i]) begin
        w_ones = w_ones + NW'(1);
      end
      if (smp_data[i] != w_lvl) begin
        if (smp_data[i]) begin
          w_rise = w_rise + NW'(1);
          w_tlow = w_racc;
        end else begin
          w_fall  = w_fall + NW'(1);
          w_thigh = w_racc;
        end
        w_lvl  = smp_data[i];
        w_racc = CW'(1);
      end else if (w_racc == '1) begin
        w_rsat = 1'b1;
      end else begin
        w_racc = w_racc + CW'(1);
      end
    end
  end

  logic [NW:0] w_sel;

  always_comb begin
    w_sel = '0;
    case (edge_mode)
      2'b00:   w_sel = {1'b0, w_rise};
      2'b01:   w_sel = {1'b0, w_fall};
      default: w_sel = {1'b0, w_rise} + {1'b0, w_fall};
    endcase
  end

  logic gate_end;
  assign gate_end = run & run_d & (gcnt == GATE_LAST);

  // The word arriving in the gate-end cycle seeds the next gate, so the
  // accumulator base restarts from zero on that cycle.
  logic [CW-1:0] base_freq;
  logic [CW-1:0] base_ones;
  logic          base_sat;
  logic          base_seen;
  logic [SW-1:0] sum_freq;
  logic [SW-1:0] sum_ones;
  logic          ovf_freq;
  logic          ovf_ones;
  logic [CW-1:0] nxt_freq;
  logic [CW-1:0] nxt_ones;
  logic          nxt_sat;
  logic          nxt_seen;

  always_comb begin
    base_freq = gate_end ? '0 : acc_freq;
    base_ones = gate_end ? '0 : acc_ones;
    base_sat  = gate_end ? 1'b0 : acc_sat;
    base_seen = gate_end ? 1'b0 : acc_seen;
    sum_freq  = SW'(base_freq) + (smp_valid ? SW'(w_sel) : '0);
    sum_ones  = SW'(base_ones) + (smp_valid ? SW'(w_ones) : '0);
    ovf_freq  = |sum_freq[SW-1:CW];
    ovf_ones  = |sum_ones[SW-1:CW];
    nxt_freq  = ovf_freq ? '1 : sum_freq[CW-1:0];
    nxt_ones  = ovf_ones ? '1 : sum_ones[CW-1:0];
    nxt_sat   = base_sat | (smp_valid & (ovf_freq | ovf_ones | w_rsat));
    nxt_seen  = base_seen | (smp_valid & ((w_rise != '0) | (w_fall != '0)));
  end

  // Gate counter is held at 0 for the cycle run first rises, so the first
  // gate spans that cycle plus GATE_CYC-1 counted cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gcnt  <= '0;
      run_d <= 1'b0;
    end else begin
      run_d <= run;
      if (!run || !run_d || gate_end) begin
        gcnt <= '0;
      end else begin
        gcnt <= gcnt + GW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_freq <= '0;
      acc_ones <= '0;
      acc_sat  <= 1'b0;
      acc_seen <= 1'b0;
    end else if (!run) begin
      acc_freq <= '0;
      acc_ones <= '0;
      acc_sat  <= 1'b0;
      acc_seen <= 1'b0;
    end else begin
      acc_freq <= nxt_freq;
      acc_ones <= nxt_ones;
      acc_sat  <= nxt_sat;
      acc_seen <= nxt_seen;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev    <= 1'b0;
      run_acc <= '0;
      thigh   <= '0;
      tlow    <= '0;
    end else if (smp_valid) begin
      prev    <= w_lvl;
      run_acc <= w_racc;
      thigh   <= w_thigh;
      tlow    <= w_tlow;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_freq  <= '0;
      res_ones  <= '0;
      res_thigh <= '0;
      res_tlow  <= '0;
      res_flags <= '0;
    end else if (gate_end) begin
      res_valid <= 1'b1;
      res_freq  <= acc_freq;
      res_ones  <= acc_ones;
      res_thigh <= acc_seen ? thigh : '0;
      res_tlow  <= acc_seen ? tlow : '0;
      res_flags <= {~acc_seen, res_valid & ~res_ready, acc_sat};
    end else if (res_valid && res_ready) begin
      res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sig_meter_core.sv
// Bench for sig_meter_core: two instances (CW=16 and CW=6) on shared stimulus,
// checked by vector table, directed sequences and a sample-history model.
module tb_sig_meter_core;

  localparam int W = 8;
  localparam int G = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        smp_valid = 1'b0;
  logic [7:0]  smp_data = '0;
  logic        run = 1'b0;
  logic [1:0]  edge_mode = '0;
  logic        res_ready = 1'b0;

  logic        va, vs;
  logic [15:0] fa, oa, ha, la;
  logic [5:0]  fs, os, hs, ls;
  logic [2:0]  flg_a, flg_s;

  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sig_meter_core #(.W(8), .GATE_CYC(16), .CW(16)) u_a (
    .clk(clk), .rst_n(rst_n), .smp_valid(smp_valid), .smp_data(smp_data),
    .run(run), .edge_mode(edge_mode), .res_valid(va), .res_ready(res_ready),
    .res_freq(fa), .res_ones(oa), .res_thigh(ha), .res_tlow(la), .res_flags(flg_a)
  );

  sig_meter_core #(.W(8), .GATE_CYC(16), .CW(6)) u_s (
    .clk(clk), .rst_n(rst_n), .smp_valid(smp_valid), .smp_data(smp_data),
    .run(run), .edge_mode(edge_mode), .res_valid(vs), .res_ready(res_ready),
    .res_freq(fs), .res_ones(os), .res_thigh(hs), .res_tlow(ls), .res_flags(flg_s)
  );

  // ---------------- reference model: full sample history since reset
  bit       hist[$];
  int       pos[$];
  bit [1:0] hmode[$];
  int       gsi;
  int       rl;
  int       mx[2];
  int       e_v[2], e_f[2], e_o[2], e_h[2], e_l[2];
  bit [2:0] e_g[2];
  int       a_v[2], a_f[2], a_o[2], a_h[2], a_l[2];
  logic [2:0] a_g[2];

  function automatic int last_run(bit pol, int m);
    for (int k = hist.size() - 1; k >= 0; k--) begin
      bit pv;
      pv = (k == 0) ? 1'b0 : hist[k-1];
      if (pv == pol && hist[k] != pol) begin
        int len;
        len = (k == 0) ? 0 : pos[k-1];
        return (len > m) ? m : len;
      end
    end
    return 0;
  endfunction

  task automatic gate_rec(input int i);
    int rf, ro;
    bit seen, rs, ovr;
    rf = 0; ro = 0; seen = 0; rs = 0;
    for (int k = gsi; k < hist.size(); k++) begin
      bit p;
      p = (k == 0) ? 1'b0 : hist[k-1];
      if (hist[k]) ro++;
      if (hist[k] != p) begin
        seen = 1;
        if (hmode[k] == 2'd0 ? hist[k] : (hmode[k] == 2'd1 ? !hist[k] : 1'b1)) rf++;
      end
      if (pos[k] > mx[i]) rs = 1;
    end
    ovr = (e_v[i] != 0) && !res_ready;
    e_f[i] = (rf > mx[i]) ? mx[i] : rf;
    e_o[i] = (ro > mx[i]) ? mx[i] : ro;
    e_h[i] = seen ? last_run(1'b1, mx[i]) : 0;
    e_l[i] = seen ? last_run(1'b0, mx[i]) : 0;
    e_g[i] = {~seen, ovr, (rf > mx[i]) || (ro > mx[i]) || rs};
    e_v[i] = 1;
  endtask

  task automatic model_step();
    bit ge;
    if (!rst_n) begin
      hist.delete(); pos.delete(); hmode.delete();
      gsi = 0; rl = 0;
      for (int i = 0; i < 2; i++) begin
        e_v[i] = 0; e_f[i] = 0; e_o[i] = 0; e_h[i] = 0; e_l[i] = 0; e_g[i] = '0;
      end
    end else begin
      ge = run && rl > 0 && (rl % G) == 0;
      for (int i = 0; i < 2; i++) begin
        if (ge) gate_rec(i);
        else if (e_v[i] != 0 && res_ready) e_v[i] = 0;
      end
      if (ge) gsi = hist.size();
      if (smp_valid) begin
        for (int b = 0; b < W; b++) begin
          bit s;
          int np;
          s = smp_data[b];
          np = (hist.size() > 0 && hist[$] == s) ? pos[$] + 1 : 1;
          hist.push_back(s); pos.push_back(np); hmode.push_back(edge_mode);
        end
      end
      if (!run) gsi = hist.size();
      rl = run ? rl + 1 : 0;
    end
  endtask

  task automatic check_all();
    a_v[0] = int'(va); a_f[0] = int'(fa); a_o[0] = int'(oa); a_h[0] = int'(ha); a_l[0] = int'(la); a_g[0] = flg_a;
    a_v[1] = int'(vs); a_f[1] = int'(fs); a_o[1] = int'(os); a_h[1] = int'(hs); a_l[1] = int'(ls); a_g[1] = flg_s;
    for (int i = 0; i < 2; i++) begin
      n_tests++;
      if (a_v[i] != e_v[i]) begin
        n_fail++;
        $display("FAIL valid[%0d] t=%0t: got %0d need %0d", i, $time, a_v[i], e_v[i]);
      end
      if (e_v[i] != 0) begin
        n_tests++;
        if (a_f[i] != e_f[i] || a_o[i] != e_o[i] || a_h[i] != e_h[i] || a_l[i] != e_l[i] || a_g[i] != e_g[i]) begin
          n_fail++;
          $display("FAIL record[%0d] t=%0t: got f=%0d o=%0d h=%0d l=%0d flg=%b need f=%0d o=%0d h=%0d l=%0d flg=%b",
                   i, $time, a_f[i], a_o[i], a_h[i], a_l[i], a_g[i], e_f[i], e_o[i], e_h[i], e_l[i], e_g[i]);
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic check_zero(input string nm);
    n_tests++;
    if ({va, fa, oa, ha, la, flg_a, vs, fs, os, hs, ls, flg_s} !== '0) begin
      n_fail++;
      $display("FAIL %s: got %h need 0", nm, {va, fa, oa, ha, la, flg_a, vs, fs, os, hs, ls, flg_s});
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; run = 1'b0; smp_valid = 1'b0; res_ready = 1'b0;
    tick();
    tick();
    check_zero("reset_state");
    rst_n = 1'b1;
  endtask

  task automatic wait_valid(input string nm);
    int t;
    t = 0;
    while (a_v[0] == 0 && t < 4 * G) begin
      tick();
      t++;
    end
    if (a_v[0] == 0) begin
      n_tests++; n_fail++;
      $display("FAIL %s: got no record need one within %0d cycles", nm, 4 * G);
    end
  endtask

  // ---------------- vector table
  typedef struct {
    logic [39:0] pat;
    int          plen;
    int          sw;
    logic [7:0]  post;
    logic [1:0]  mode;
    int          inst;
    int          rec;
    int          f, o, h, l;
    logic [2:0]  flg;
  } vec_t;

  vec_t tbl[11];

  function automatic logic [7:0] word_of(vec_t v, int k);
    logic [39:0] p;
    p = v.pat;
    if (k >= v.sw) return v.post;
    return p[8*(k % v.plen) +: 8];
  endfunction

  initial begin
    logic [7:0] d;
    mx[0] = 65535;
    mx[1] = 63;
    gsi = 0; rl = 0;
    for (int i = 0; i < 2; i++) begin
      e_v[i] = 0; e_f[i] = 0; e_o[i] = 0; e_h[i] = 0; e_l[i] = 0; e_g[i] = '0;
    end

    tbl[0]  = '{40'hF0, 1, 1000, 8'h00, 2'd2, 0, 1, 31, 64, 4, 4, 3'b000};
    tbl[1]  = '{40'hF0, 1, 1000, 8'h00, 2'd2, 0, 2, 32, 64, 4, 4, 3'b000};
    tbl[2]  = '{40'hF0, 1, 1000, 8'h00, 2'd0, 0, 2, 16, 64, 4, 4, 3'b000};
    tbl[3]  = '{40'hF0, 1, 1000, 8'h00, 2'd1, 0, 1, 15, 64, 4, 4, 3'b000};
    tbl[4]  = '{40'h00FFFFFF00, 5, 1000, 8'h00, 2'd0, 0, 1, 3, 72, 24, 16, 3'b000};
    tbl[5]  = '{40'h00FFFFFF00, 5, 1000, 8'h00, 2'd0, 0, 2, 4, 80, 24, 16, 3'b000};
    tbl[6]  = '{40'h00, 1, 1000, 8'h00, 2'd2, 0, 1, 0, 0, 0, 0, 3'b100};
    tbl[7]  = '{40'hFF, 1, 1000, 8'h00, 2'd2, 0, 2, 0, 128, 0, 0, 3'b100};
    tbl[8]  = '{40'hFF, 1, 16, 8'h00, 2'd2, 1, 1, 1, 63, 0, 0, 3'b001};
    tbl[9]  = '{40'hFF, 1, 16, 8'h00, 2'd2, 1, 2, 1, 0, 63, 0, 3'b001};
    tbl[10] = '{40'hFF, 1, 16, 8'h00, 2'd2, 0, 2, 1, 0, 128, 0, 3'b000};

    for (int t = 0; t < 11; t++) begin
      int k, recs, lim, ix;
      bit got;
      do_reset();
      run = 1'b1; res_ready = 1'b1; smp_valid = 1'b1; edge_mode = tbl[t].mode;
      k = 0; recs = 0; got = 0; ix = tbl[t].inst;
      lim = (tbl[t].rec + 1) * G + 8;
      while (!got && k < lim) begin
        smp_data = word_of(tbl[t], k);
        tick();
        k++;
        if (a_v[ix] != 0) begin
          recs++;
          if (recs == tbl[t].rec) got = 1;
        end
      end
      n_tests++;
      if (!got) begin
        n_fail++;
        $display("FAIL vec%0d: got %0d records need record %0d", t, recs, tbl[t].rec);
      end else if (a_f[ix] != tbl[t].f || a_o[ix] != tbl[t].o || a_h[ix] != tbl[t].h ||
                   a_l[ix] != tbl[t].l || a_g[ix] != tbl[t].flg) begin
        n_fail++;
        $display("FAIL vec%0d: got f=%0d o=%0d h=%0d l=%0d flg=%b need f=%0d o=%0d h=%0d l=%0d flg=%b",
                 t, a_f[ix], a_o[ix], a_h[ix], a_l[ix], a_g[ix],
                 tbl[t].f, tbl[t].o, tbl[t].h, tbl[t].l, tbl[t].flg);
      end
    end

    // Overrun: consumer stalls across two gate ends, then one ready pulse.
    do_reset();
    run = 1'b1; res_ready = 1'b0; smp_valid = 1'b1; smp_data = 8'hF0; edge_mode = 2'd2;
    wait_valid("ovr_first");
    repeat (G) tick();
    n_tests++;
    if (!(a_v[0] == 1 && a_g[0][1] == 1'b1 && a_f[0] == 32)) begin
      n_fail++;
      $display("FAIL overrun: got v=%0d flg=%b f=%0d need v=1 flg=x1x f=32", a_v[0], a_g[0], a_f[0]);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    n_tests++;
    if (a_v[0] != 0) begin
      n_fail++;
      $display("FAIL ready_drop: got valid=%0d need 0", a_v[0]);
    end

    // Reset mid-gate with a record pending.
    wait_valid("pend_rec");
    repeat (3) tick();
    n_tests++;
    if (a_v[0] != 1) begin
      n_fail++;
      $display("FAIL pend_hold: got valid=%0d need 1", a_v[0]);
    end
    rst_n = 1'b0;
    tick();
    check_zero("rst_mid");

    // Hold then restart: first record exactly G+1 cycles after run rises.
    rst_n = 1'b1; run = 1'b0; res_ready = 1'b1;
    begin
      int seen_v, t;
      seen_v = 0;
      repeat (40) begin
        tick();
        if (a_v[0] != 0 || a_v[1] != 0) seen_v = 1;
      end
      n_tests++;
      if (seen_v != 0) begin
        n_fail++;
        $display("FAIL hold: got record while run=0 need none");
      end
      run = 1'b1;
      t = 0;
      while (a_v[0] == 0 && t < 4 * G) begin
        tick();
        t++;
      end
      n_tests++;
      if (t != G + 1) begin
        n_fail++;
        $display("FAIL restart_lat: got %0d cycles need %0d", t, G + 1);
      end
    end

    // Randomised traffic against the model.
    do_reset();
    run = 1'b1; res_ready = 1'b1; d = 8'hF0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 5) == 0) begin
        case ($urandom_range(0, 3))
          0: d = 8'($urandom);
          1: d = 8'h00;
          2: d = 8'hFF;
          default: d = 8'h0F;
        endcase
      end
      smp_data  = d;
      smp_valid = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 39) == 0) edge_mode = 2'($urandom);
      if ($urandom_range(0, 14) == 0) res_ready = ~res_ready;
      if (run) begin
        if ($urandom_range(0, 399) == 0) run = 1'b0;
      end else if ($urandom_range(0, 9) == 0) begin
        run = 1'b1;
      end
      rst_n = ($urandom_range(0, 1499) != 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sig_meter_core.md
Name: sig_meter_core

Overview:
- Parametrised, gated signal meter for a word-packed 1-bit sample stream.
- Each input word carries W consecutive samples. Per gate window the block measures edge count, ones count (duty numerator), and the last completed high-run and low-run lengths.
- Results go out as a valid/ready record to the display/paging logic downstream.
- Generalises the fixed 32-bit meter with selectable width, gate length, counter width, edge mode, run/hold, overrun, saturation and no-signal reporting.

Parameters:
- W, 32: sample bits per word. Bit 0 is the oldest sample, bit W-1 the newest.
- GATE_CYC, 31250000: gate window length in clk cycles.
- CW, 32: width of all result counters.

Ports:
- clk, in, 1: single clock, all logic on rising edge.
- rst_n, in, 1: synchronous reset, active low.
- smp_valid, in, 1: smp_data valid this cycle.
- smp_data, in, W: packed samples.
- run, in, 1: 1 = measure, 0 = hold/idle.
- edge_mode, in, 2: selects which edges res_freq counts. 00 = rising, 01 = falling, 10/11 = both.
- res_valid, out, 1: result record valid.
- res_ready, in, 1: consumer accepts the record.
- res_freq, out, CW: selected edges in the gate.
- res_ones, out, CW: count of 1 samples in the gate.
- res_thigh, out, CW: last completed high-run length, in samples.
- res_tlow, out, CW: last completed low-run length, in samples.
- res_flags, out, 3: {no_signal, overrun, sat}.

Behaviour:
- **Clock and reset.** One clock. Reset is synchronous and active-low.
- **Reset state.**
  - All outputs are 0; res_valid = 0.
  - Gate counter = 0; accumulators = 0.
  - Previous-sample register prev = 0.
  - Run accumulator = 0, current level = 0.
- **Edge definition.** Edges are counted between adjacent samples. Bit 0 of a word is compared with prev, which holds bit W-1 of the last valid word. prev updates only on smp_valid.
- **Run tracking.**
  - Runs continue across words.
  - On a falling edge the completed high-run length is latched into an internal thigh register; on a rising edge the completed low-run length is latched into tlow.
  - When a word contains several edges, the register value after the word equals the latest completed run of each polarity.
  - The run accumulator saturates at 2^CW-1 and sets the gate's sat flag.
  - Run tracking continues regardless of run.
- **Gate window.**
  - With run = 1, the gate counter counts 0..GATE_CYC-1.
  - On the cycle the count equals GATE_CYC-1, the gate-end event fires.
  - A word valid in the gate-end cycle is counted in the new gate, not the ending one.
  - The edge and ones accumulators saturate at 2^CW-1 and set sat.
- **Gate end.**
  - The next cycle registers res_freq, res_ones, res_thigh and res_tlow, plus flags, and asserts res_valid. Latency is 1 cycle after gate end.
  - no_signal = 1 when the gate saw zero edges of either polarity. In that case res_thigh and res_tlow are 0.
- **Handshake.**
  - The record and res_valid hold until res_valid & res_ready, after which res_valid drops the next cycle.
  - If a new gate ends while res_valid = 1 and no handshake occurs in that cycle, the new record replaces the old one and its overrun flag = 1.
  - A handshake in the same cycle as the replacement yields overrun = 0.
- **Run/hold.**
  - run = 0: gate counter and accumulators are held cleared and no new records are produced. A pending record stays valid until accepted.
  - run 0→1: the gate starts at count 0 in the next cycle.
  - run dropping mid-gate discards the partial gate.
- **Edge mode.** edge_mode is sampled every cycle. A mid-gate change affects only subsequent words.
- **Reset mid-operation.** Asserting rst_n = 0 clears everything, including a pending record, in the same clock edge.

Test Plan:
- **Steady waveform.** W=8, GATE_CYC=16, CW=16, smp_valid=1, smp_data=8'hF0 from reset, edge_mode=10.
  - First record: freq=31, ones=64, thigh=4, tlow=4.
  - Second record: freq=32.
  - With edge_mode=00: freq=16 each gate.
- **Long runs.** Same config, words 00, FF, FF, FF, 00 repeated, edge_mode=00.
  - Expected: thigh=24, tlow=16, ones=24 per 5 words accounted.
- **Constant input.**
  - smp_data=0 for a whole gate: flags no_signal=1, freq=0, ones=0, thigh=0, tlow=0.
  - smp_data=FF: no_signal=1, ones=128.
- **Overrun.** res_ready=0 across two gate ends.
  - Second record replaces the first with overrun=1.
  - res_ready pulse then drops res_valid one cycle later.
- **Saturation.** CW=6, data FF for 16 words.
  - Expected: ones=63, sat=1, and thigh saturated at 63 once the run ends.
- **Reset and hold.**
  - rst_n=0 mid-gate with res_valid=1: next cycle all outputs are 0.
  - run=0 for 40 cycles: no record.
  - run→1: first record exactly GATE_CYC+1 cycles later.
